vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz display path. It runs on the 25 MHz pixel clock and produces the `DrawX`/`DrawY` scan coordinates and the `blank` qualifier that every sprite-drawing stage (turret, tank, map renderers) consumes. It also produces the active-low `hs`/`vs` syncs that drive the VGA connector, and a once-per-frame `frame_end` strobe that game logic uses to update sprite positions between frames.

## Interface
Parameters:
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_VISIBLE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.

Ports:
- `vga_clk`  in  1: pixel clock; the only clock in the block.
- `reset`  in  1: synchronous, active-high reset.
- `DrawX`  out  10: current horizontal count, 0..H_TOTAL-1.
- `DrawY`  out  10: current vertical count, 0..V_TOTAL-1.
- `blank`  out  1: 1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanking.
- `hs`  out  1: horizontal sync, active low.
- `vs`  out  1: vertical sync, active low.
- `frame_end`  out  1: one-cycle pulse on the last pixel of the frame.

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default).
  - Both totals must be ≤1024; this is elaborate-time checked.
- Counters:
  - Horizontal counter `hc` increments every cycle.
  - At H_TOTAL-1, `hc` wraps to 0 and vertical counter `vc` advances.
  - At H_TOTAL-1 with `vc` at V_TOTAL-1, both wrap to 0.
- All outputs are registered. Each output is computed from the next-state counter values, so every output in a cycle describes the same pixel (`DrawX`,`DrawY`).
- `DrawX` = `hc`; `DrawY` = `vc`.
- `hs` = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
- `vs` = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC (490..491 by default).
- `blank` = (DrawX<H_VISIBLE) && (DrawY<V_VISIBLE).
- `frame_end` = 1 iff DrawX==H_TOTAL-1 and DrawY==V_TOTAL-1.
- Comparisons are unsigned, 10-bit; no other arithmetic is used.

## Timing
- Reset values, with outputs valid in the first cycle after `reset` is sampled high: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_end=0.
- Reset mid-frame: the next cycle is pixel (0,0) regardless of position. Any sync pulse in progress is terminated; no partial pulse continues.
- After `reset` deasserts, the cycle following pixel (0,0) is pixel (1,0). The counters advance every cycle with no stall input.
- Frame period: H_TOTAL*V_TOTAL cycles (420000 by default). `frame_end` fires once per period.
- Line period: H_TOTAL cycles. `hs` pulses once per line, including during vertical blanking.
- Wrap-around:
  - From (H_TOTAL-1, y) the next pixel is (0, y+1).
  - From (H_TOTAL-1, V_TOTAL-1) the next pixel is (0,0).
  - DrawY never reaches V_TOTAL.
- Consumer latency contract: downstream sprite stages read the ROM in one cycle and register their color in the next. Their color output for pixel (x,y) therefore appears two cycles after DrawX=x.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined:
  - `hs` and `vs` pass through a 2-stage delay so they align with downstream registered color output.
  - The delay stages reset to 1.
  - `blank`, `DrawX`, `DrawY` and `frame_end` are unchanged.
  - Sync edges occur 2 cycles later than listed above, e.g. `hs` falls when the DrawX counter is at 658.
- Undefined:
  - `hs`/`vs` align with `DrawX`/`DrawY` exactly as in Operation.

## Test plan
- Reset, then release and run 3 cycles -> reset cycle shows (0,0), blank=1, hs=1, vs=1, frame_end=0; the next cycles show DrawX=1 then 2, with DrawY=0.
- Run one line -> hs=0 for exactly DrawX 656..751 (96 cycles); blank=0 from DrawX 640; DrawX wraps 799->0 as DrawY goes 0->1.
- Run a full frame -> vs=0 only while DrawY is 490..491 (1600 cycles); frame_end=1 only at (799,524); next cycle shows (0,0).
- Over 2 frames, count frame_end pulses -> 2 pulses, exactly 420000 cycles apart.
- Assert reset for 1 cycle at (700,300) while hs=0 -> next cycle shows (0,0) with hs=1, and counting resumes normally.
- With `VGA_SYNC_ALIGN_EN` defined, run one line -> hs falls when DrawX reads 658 and rises when DrawX reads 754; blank timing is identical to the undefined build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- pixel-timing generator for the 640x480@60 Hz display path.
//
// Produces the scan coordinates (DrawX, DrawY), the visible-pixel qualifier
// (blank), the active-low VGA syncs (hs, vs) and a once-per-frame strobe
// (frame_end). Every output is registered and computed from the next-state
// counter values, so all outputs in a given cycle describe the same pixel.
//
// Ports:
//   vga_clk    in   1  pixel clock (only clock)
//   reset      in   1  synchronous, active-high reset
//   DrawX      out 10  horizontal count, 0..H_TOTAL-1
//   DrawY      out 10  vertical count,   0..V_TOTAL-1
//   blank      out  1  1 = visible pixel, 0 = blanking
//   hs         out  1  horizontal sync, active low
//   vs         out  1  vertical sync, active low
//   frame_end  out  1  one-cycle pulse on the last pixel of the frame
//
// Optional feature macro: VGA_SYNC_ALIGN_EN
//   When defined, hs/vs are delayed by two extra register stages (reset to 1)
//   so they line up with the color output of the two-cycle sprite pipeline.

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    // Inclusive bounds keep every compare within 10 bits even at a 1024 total.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic       blank_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       fe_nxt;
    logic       hs_p0;
    logic       vs_p0;

    // DrawX/DrawY are the counters themselves; outputs derive from their next state.
    always_comb begin
        hc_nxt = DrawX + 10'd1;
        vc_nxt = DrawY;
        if (DrawX == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        blank_nxt = (hc_nxt <= H_VIS_LAST) && (vc_nxt <= V_VIS_LAST);
        hs_nxt    = !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
        vs_nxt    = !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
        fe_nxt    = (hc_nxt == H_LAST) && (vc_nxt == V_LAST);
    end

    // ---- stage p0: counters and pixel-aligned outputs ----
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX     <= '0;
            DrawY     <= '0;
            blank     <= 1'b1;
            hs_p0     <= 1'b1;
            vs_p0     <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            DrawX     <= hc_nxt;
            DrawY     <= vc_nxt;
            blank     <= blank_nxt;
            hs_p0     <= hs_nxt;
            vs_p0     <= vs_nxt;
            frame_end <= fe_nxt;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_p1;
    logic vs_p1;

    // ---- stages p1/p2: sync delay matching the sprite ROM + color registers ----
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_p1 <= 1'b1;
            vs_p1 <= 1'b1;
            hs    <= 1'b1;
            vs    <= 1'b1;
        end else begin
            hs_p1 <= hs_p0;
            vs_p1 <= vs_p0;
            hs    <= hs_p1;
            vs    <= vs_p1;
        end
    end
`else
    assign hs = hs_p0;
    assign vs = vs_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Uses a reduced geometry so that several whole
// frames fit in a short run. The reference model tracks a single linear pixel
// index p within the frame; coordinates are p % H_TOTAL and p / H_TOTAL, and
// every output is derived from those coordinates by the timing rules.

module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 5;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 31
    localparam int VT = VV + VF + VS + VB;   // 15
    localparam int FRAME = HT * VT;          // 465

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [9:0] DrawX, DrawY;
    logic       blank, hs, vs, frame_end;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .blank    (blank),
        .hs       (hs),
        .vs       (vs),
        .frame_end(frame_end)
    );

    always #20 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state
    int p = 0;
    bit hs_d1 = 1'b1, hs_d2 = 1'b1, vs_d1 = 1'b1, vs_d2 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit hs_rule(input int pix);
        int x = pix % HT;
        return !(x >= HV + HF && x < HV + HF + HS);
    endfunction

    function automatic bit vs_rule(input int pix);
        int y = pix / HT;
        return !(y >= VV + VF && y < VV + VF + VS);
    endfunction

    // One clock with reset=r, then compare every output against the model.
    task automatic step(input bit r);
        int x, y;
        bit exp_hs, exp_vs;
        reset = r;
        @(posedge vga_clk);
        #1;
        cyc++;
        if (r) begin
            p = 0;
            hs_d1 = 1'b1; hs_d2 = 1'b1;
            vs_d1 = 1'b1; vs_d2 = 1'b1;
        end else begin
            hs_d2 = hs_d1; hs_d1 = hs_rule(p);
            vs_d2 = vs_d1; vs_d1 = vs_rule(p);
            p = (p + 1) % FRAME;
        end
        x = p % HT;
        y = p / HT;
`ifdef VGA_SYNC_ALIGN_EN
        exp_hs = hs_d2;
        exp_vs = vs_d2;
`else
        exp_hs = hs_rule(p);
        exp_vs = vs_rule(p);
`endif
        chk("DrawX", 32'(DrawX), 32'(x));
        chk("DrawY", 32'(DrawY), 32'(y));
        chk("blank", 32'(blank), 32'((x < HV) && (y < VV)));
        chk("hs", 32'(hs), 32'(exp_hs));
        chk("vs", 32'(vs), 32'(exp_vs));
        chk("frame_end", 32'(frame_end), 32'((x == HT - 1) && (y == VT - 1)));
    endtask

    initial begin
        int fe_cnt, fe_first, fe_second, hs_low, vs_low, guard;

        // Reset cycle and the following pixels.
        step(1'b1);
        chk("reset_x", 32'(DrawX), 32'd0);
        chk("reset_hs", 32'(hs), 32'd1);

        // Two uninterrupted frames: pulse count and spacing, sync widths.
        fe_cnt = 0; fe_first = -1; fe_second = -1; hs_low = 0; vs_low = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0);
            if (frame_end === 1'b1) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = cyc;
                else if (fe_second < 0) fe_second = cyc;
            end
            if (hs === 1'b0) hs_low++;
            if (vs === 1'b0) vs_low++;
        end
        chk("fe_count", 32'(fe_cnt), 32'd2);
        chk("fe_gap", 32'(fe_second - fe_first), 32'(FRAME));
        chk("hs_low_cycles", 32'(hs_low), 32'(2 * VT * HS));
        chk("vs_low_cycles", 32'(vs_low), 32'(2 * VS * HT));

        // Reset mid-frame while inside the horizontal sync pulse.
        guard = 0;
        while (!(p % HT == HV + HF + 2 && p / HT == VV / 2) && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
        chk("reach_mid_frame", 32'(guard < 2 * FRAME), 32'd1);
`ifndef VGA_SYNC_ALIGN_EN
        chk("hs_low_before_reset", 32'(hs), 32'd0);
`endif
        step(1'b1);
        chk("midreset_x", 32'(DrawX), 32'd0);
        chk("midreset_y", 32'(DrawY), 32'd0);
        chk("midreset_hs", 32'(hs), 32'd1);
        for (int i = 0; i < HT + 3; i++) step(1'b0);

        // Randomized reset pulses over several frames.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
